// File: rtl/serial_add_pkg.sv
// Package for the serial adder scheduler: FSM state type, default sizes
// and the round-robin pick helper shared by the arbiter.
package serial_add_pkg;

  localparam int WIDTH_DEF = 8;
  localparam int NREQ_DEF  = 4;
  localparam int MAX_NREQ  = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // First asserted valid at or after ptr, wrapping modulo nreq.
  // Returns the winning index, or -1 when nothing is requesting.
  function automatic int rr_pick(input logic [MAX_NREQ-1:0] valid,
                                 input int nreq,
                                 input int ptr);
    int pick;
    int j;
    pick = -32'sd1;
    for (int i = 0; i < MAX_NREQ; i++) begin
      if (i < nreq) begin
        j = (ptr + i) % nreq;
        if ((pick < 32'sd0) && valid[j]) begin
          pick = j;
        end else begin
          pick = pick;
        end
      end else begin
        pick = pick;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/serial_add_sched_if.sv
// Request/response bundle between the clients and the serial adder scheduler.
// Optional macro SERIAL_SUB_EN adds the per-requester subtract select.
interface serial_add_sched_if #(
  parameter int WIDTH = serial_add_pkg::WIDTH_DEF,
  parameter int NREQ  = serial_add_pkg::NREQ_DEF
) ();

  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_a;
  logic [NREQ*WIDTH-1:0] req_b;
`ifdef SERIAL_SUB_EN
  logic [NREQ-1:0]       req_sub;
`endif
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [IDW-1:0]        rsp_id;
  logic [WIDTH:0]        rsp_result;

`ifdef SERIAL_SUB_EN
  modport master (
    output req_valid, req_a, req_b, req_sub, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_result
  );
  modport slave (
    input  req_valid, req_a, req_b, req_sub, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_result
  );
`else
  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_result
  );
  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_result
  );
`endif

endinterface

// File: rtl/serial_add_core.sv
// Bit-serial adder datapath: operand shift registers, one full adder,
// carry flip-flop and the partial-sum shift register. `result` is the
// look-ahead value the full sum takes once the current shift completes,
// so the scheduler can capture it on the final shift cycle.
module serial_add_core #(
  parameter int WIDTH = serial_add_pkg::WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift,
  input  logic             carry_init,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH:0]   result
);

  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-2:0] sum_r;   // the final sum bit never needs storing here
  logic             carry_r;
  logic             sum_bit_s;
  logic             carry_next_s;

  // Full adder on the current operand LSBs plus the look-ahead result.
  always_comb begin
    sum_bit_s    = a_r[0] ^ b_r[0] ^ carry_r;
    carry_next_s = (a_r[0] & b_r[0]) | (carry_r & (a_r[0] ^ b_r[0]));
    result       = {carry_next_s, sum_bit_s, sum_r};
  end

  // Operand load, then LSB-first shifting with sum bits entering at the MSB.
  always_ff @(posedge clk) begin
    if (!rst) begin
      a_r     <= {WIDTH{1'b0}};
      b_r     <= {WIDTH{1'b0}};
      sum_r   <= {(WIDTH-1){1'b0}};
      carry_r <= 1'b0;
    end else if (load) begin
      a_r     <= a;
      b_r     <= b;
      sum_r   <= {(WIDTH-1){1'b0}};
      carry_r <= carry_init;
    end else if (shift) begin
      a_r     <= {1'b0, a_r[WIDTH-1:1]};
      b_r     <= {1'b0, b_r[WIDTH-1:1]};
      sum_r   <= {sum_bit_s, sum_r[WIDTH-2:1]};
      carry_r <= carry_next_s;
    end else begin
      a_r     <= a_r;
      b_r     <= b_r;
      sum_r   <= sum_r;
      carry_r <= carry_r;
    end
  end

endmodule

// File: rtl/serial_add_sched.sv
// Round-robin scheduler sharing one bit-serial adder among NREQ requesters.
// Grants one operand pair at a time, sequences the core for WIDTH shifts and
// returns {carry, sum} tagged with the requester id over a valid/ready port.
// Optional macro SERIAL_SUB_EN enables per-requester subtraction (A + ~B + 1).
module serial_add_sched #(
  parameter int WIDTH = serial_add_pkg::WIDTH_DEF,
  parameter int NREQ  = serial_add_pkg::NREQ_DEF
) (
  input logic               clk,
  input logic               rst,
  serial_add_sched_if.slave bus
);

  import serial_add_pkg::*;

  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);
  localparam logic [IDW-1:0] ID_LAST  = IDW'(NREQ - 1);

  state_t           state_r;
  logic [IDW-1:0]   rr_ptr_r;
  logic [IDW-1:0]   id_r;
  logic [CW-1:0]    cnt_r;
  logic             rsp_valid_r;
  logic [IDW-1:0]   rsp_id_r;
  logic [WIDTH:0]   rsp_result_r;

  logic [MAX_NREQ-1:0] valid_pad_s;
  int                  pick_s;
  logic [NREQ-1:0]     ready_s;
  logic                hs_s;
  logic [IDW-1:0]      gnt_s;
  logic [WIDTH-1:0]    a_sel_s;
  logic [WIDTH-1:0]    b_sel_s;
  logic [WIDTH-1:0]    b_load_s;
  logic                cin_s;
  logic                shift_s;
  logic [WIDTH:0]      core_res_s;
`ifdef SERIAL_SUB_EN
  logic                sub_sel_s;
`endif

  // Round-robin arbiter, one-hot grant and operand mux for the granted slot.
  always_comb begin
    valid_pad_s             = {MAX_NREQ{1'b0}};
    valid_pad_s[NREQ-1:0]   = bus.req_valid;
    pick_s                  = rr_pick(valid_pad_s, NREQ, int'(rr_ptr_r));
    ready_s                 = {NREQ{1'b0}};
    gnt_s                   = {IDW{1'b0}};
    a_sel_s                 = {WIDTH{1'b0}};
    b_sel_s                 = {WIDTH{1'b0}};
`ifdef SERIAL_SUB_EN
    sub_sel_s               = 1'b0;
`endif
    for (int i = 0; i < NREQ; i++) begin
      ready_s[i] = rst && (state_r == IDLE) && (pick_s == i);
      gnt_s      = gnt_s   | (IDW'(i) & {IDW{ready_s[i]}});
      a_sel_s    = a_sel_s | (bus.req_a[i*WIDTH +: WIDTH] & {WIDTH{ready_s[i]}});
      b_sel_s    = b_sel_s | (bus.req_b[i*WIDTH +: WIDTH] & {WIDTH{ready_s[i]}});
`ifdef SERIAL_SUB_EN
      sub_sel_s  = sub_sel_s | (bus.req_sub[i] & ready_s[i]);
`endif
    end
    hs_s    = |(ready_s & bus.req_valid);
    shift_s = (state_r == SHIFT);
`ifdef SERIAL_SUB_EN
    b_load_s = sub_sel_s ? ~b_sel_s : b_sel_s;
    cin_s    = sub_sel_s;
`else
    b_load_s = b_sel_s;
    cin_s    = 1'b0;
`endif
  end

  serial_add_core #(.WIDTH(WIDTH)) u_core (
    .clk        (clk),
    .rst        (rst),
    .load       (hs_s),
    .shift      (shift_s),
    .carry_init (cin_s),
    .a          (a_sel_s),
    .b          (b_load_s),
    .result     (core_res_s)
  );

  // Control FSM: grant in IDLE, WIDTH shift cycles, hold the response in DONE.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r      <= IDLE;
      rr_ptr_r     <= {IDW{1'b0}};
      id_r         <= {IDW{1'b0}};
      cnt_r        <= {CW{1'b0}};
      rsp_valid_r  <= 1'b0;
      rsp_id_r     <= {IDW{1'b0}};
      rsp_result_r <= {(WIDTH+1){1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (hs_s) begin
            id_r    <= gnt_s;
            cnt_r   <= {CW{1'b0}};
            state_r <= SHIFT;
          end else begin
            state_r <= IDLE;
          end
        end
        SHIFT: begin
          cnt_r <= cnt_r + CW'(1'b1);
          if (cnt_r == CNT_LAST) begin
            rsp_result_r <= core_res_s;
            rsp_id_r     <= id_r;
            rsp_valid_r  <= 1'b1;
            state_r      <= DONE;
          end else begin
            state_r <= SHIFT;
          end
        end
        DONE: begin
          if (bus.rsp_ready) begin
            rsp_valid_r <= 1'b0;
            rr_ptr_r    <= (id_r == ID_LAST) ? {IDW{1'b0}} : (id_r + IDW'(1'b1));
            state_r     <= IDLE;
          end else begin
            state_r <= DONE;
          end
        end
        default: begin
          rsp_valid_r <= 1'b0;
          state_r     <= IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready  = ready_s;
  assign bus.rsp_valid  = rsp_valid_r;
  assign bus.rsp_id     = rsp_id_r;
  assign bus.rsp_result = rsp_result_r;

endmodule

// File: tb/tb_serial_add_sched.sv
// Self-checking bench for serial_add_sched: directed scenarios plus random
// traffic, all compared every cycle against a transaction-level reference.
module tb_serial_add_sched;

  localparam int WIDTH = 8;
  localparam int NREQ  = 4;
  localparam int IDW   = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  serial_add_sched_if #(.WIDTH(WIDTH), .NREQ(NREQ)) bus ();

  serial_add_sched #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int err_cnt = 0;
  int chk_cnt = 0;

  // requester-side stimulus state
  logic             pend [NREQ];
  logic [WIDTH-1:0] op_a [NREQ];
  logic [WIDTH-1:0] op_b [NREQ];
  logic             op_s [NREQ];

  // reference model state
  logic           m_busy = 1'b0;
  int             m_age  = 0;
  int             m_ptr  = 0;
  int             m_id   = 0;
  logic [WIDTH:0] m_res  = '0;
  int             n_rsp  = 0;
  logic [WIDTH:0] last_res;
  int             last_id;
  int             gnt_log[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int ref_pick(input logic [NREQ-1:0] v, input int ptr);
    for (int k = 0; k < NREQ; k++) begin
      if (v[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
    end
    return -1;
  endfunction

  function automatic logic [WIDTH:0] ref_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                            input logic s);
    logic [WIDTH:0] r;
    if (s) r = {1'b0, a} + {1'b0, ~b} + 9'd1;
    else   r = {1'b0, a} + {1'b0, b};
    return r;
  endfunction

  task automatic drive();
    for (int i = 0; i < NREQ; i++) begin
      bus.req_valid[i]           = pend[i];
      bus.req_a[i*WIDTH +: WIDTH] = op_a[i];
      bus.req_b[i*WIDTH +: WIDTH] = op_b[i];
`ifdef SERIAL_SUB_EN
      bus.req_sub[i]             = op_s[i];
`endif
    end
  endtask

  task automatic new_req(input int i, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic s);
    pend[i] = 1'b1;
    op_a[i] = a;
    op_b[i] = b;
`ifdef SERIAL_SUB_EN
    op_s[i] = s;
`else
    op_s[i] = 1'b0 & s;
`endif
  endtask

  // One clock: drive, check outputs at negedge, advance model, step past posedge.
  task automatic tick();
    int g;
    logic [NREQ-1:0] exp_rdy;
    logic exp_rv;
    drive();
    @(negedge clk);
    if (m_busy) m_age++;
    g = ref_pick(bus.req_valid, m_ptr);
    exp_rdy = '0;
    if (rst && !m_busy && g >= 0) exp_rdy[g] = 1'b1;
    exp_rv = m_busy && (m_age >= WIDTH + 1);
    check("req_ready", 32'(bus.req_ready), 32'(exp_rdy));
    check("rsp_valid", 32'(bus.rsp_valid), 32'(exp_rv));
    if (exp_rv) begin
      check("rsp_id", 32'(bus.rsp_id), 32'(m_id));
      check("rsp_result", 32'(bus.rsp_result), 32'(m_res));
    end
    if (!rst) begin
      m_busy = 1'b0;
      m_ptr  = 0;
    end else if (!m_busy) begin
      if (g >= 0) begin
        m_busy = 1'b1;
        m_age  = 0;
        m_id   = g;
        m_res  = ref_op(op_a[g], op_b[g], op_s[g]);
        pend[g] = 1'b0;
        gnt_log.push_back(g);
      end
    end else if (exp_rv && bus.rsp_ready) begin
      m_busy   = 1'b0;
      m_ptr    = (m_id + 1) % NREQ;
      last_res = bus.rsp_result;
      last_id  = int'(bus.rsp_id);
      n_rsp++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rsp(input int target, input string tag);
    int k;
    k = 0;
    while (n_rsp < target && k < 200) begin
      tick();
      k++;
    end
    check({tag, "_timeout"}, 32'(n_rsp >= target), 32'd1);
  endtask

  task automatic do_req(input int idx, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic s, input logic [WIDTH:0] exp_res, input string tag);
    new_req(idx, a, b, s);
    wait_rsp(n_rsp + 1, tag);
    check({tag, "_res"}, 32'(last_res), 32'(exp_res));
    check({tag, "_id"}, 32'(last_id), 32'(idx));
  endtask

  task automatic drain();
    int k;
    for (int i = 0; i < NREQ; i++) pend[i] = 1'b0;
    bus.rsp_ready = 1'b1;
    k = 0;
    while (m_busy && k < 100) begin
      tick();
      k++;
    end
    check("drain_timeout", 32'(m_busy), 32'd0);
  endtask

  task automatic reset_tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int k;
    logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] rb;
    for (int i = 0; i < NREQ; i++) begin
      pend[i] = 1'b0;
      op_a[i] = '0;
      op_b[i] = '0;
      op_s[i] = 1'b0;
    end
    bus.rsp_ready = 1'b1;
    drive();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    tick();
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_rsp_id", 32'(bus.rsp_id), 32'd0);
    check("rst_rsp_result", 32'(bus.rsp_result), 32'd0);
    check("rst_req_ready", 32'(bus.req_ready), 32'd0);
    rst = 1'b1;
    tick();

    // single requests and arithmetic boundaries
    do_req(0, 8'h5A, 8'h3C, 1'b0, 9'h096, "t1");
    do_req(1, 8'hFF, 8'h01, 1'b0, 9'h100, "ovf");
    do_req(2, 8'h00, 8'h00, 1'b0, 9'h000, "zero");
    do_req(3, 8'hFF, 8'hFF, 1'b0, 9'h1FE, "max");

    // all requesters valid from reset: round-robin order 0,1,2,3,0
    reset_tick();
    for (int i = 0; i < NREQ; i++) new_req(i, WIDTH'($urandom), WIDTH'($urandom), 1'b0);
    base = gnt_log.size();
    k = 0;
    while (gnt_log.size() < base + 5 && k < 100) begin
      tick();
      for (int i = 0; i < NREQ; i++)
        if (!pend[i]) new_req(i, WIDTH'($urandom), WIDTH'($urandom), 1'b0);
      k++;
    end
    check("rr_timeout", 32'(gnt_log.size() >= base + 5), 32'd1);
    for (int i = 0; i < 5; i++)
      if (base + i < gnt_log.size()) check("rr_order", 32'(gnt_log[base + i]), 32'(i % NREQ));
    drain();

    // backpressure: response held, no new grants while stalled
    bus.rsp_ready = 1'b0;
    new_req(1, 8'h81, 8'h7F, 1'b0);
    new_req(3, 8'h11, 8'h22, 1'b0);
    base = n_rsp;
    repeat (WIDTH + 1 + 20) tick();
    check("bp_no_drain", 32'(n_rsp), 32'(base));
    check("bp_held_result", 32'(bus.rsp_result), 32'h100);
    bus.rsp_ready = 1'b1;
    wait_rsp(base + 2, "bp_release");
    drain();

    // reset in the middle of SHIFT aborts the operation silently
    new_req(2, 8'h33, 8'h44, 1'b0);
    k = 0;
    while (!(m_busy && m_age == 3) && k < 20) begin
      tick();
      k++;
    end
    check("mid_wait", 32'(m_busy && m_age == 3), 32'd1);
    base = n_rsp;
    reset_tick();
    check("mid_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("mid_rsp_id", 32'(bus.rsp_id), 32'd0);
    check("mid_rsp_result", 32'(bus.rsp_result), 32'd0);
    repeat (WIDTH + 3) tick();
    check("mid_no_rsp", 32'(n_rsp), 32'(base));
    do_req(2, 8'h12, 8'h34, 1'b0, 9'h046, "post_rst");

`ifdef SERIAL_SUB_EN
    do_req(0, 8'h10, 8'h20, 1'b1, 9'h0F0, "sub_lt");
    do_req(1, 8'h20, 8'h10, 1'b1, 9'h110, "sub_ge");
    do_req(2, 8'h55, 8'h55, 1'b1, 9'h100, "sub_eq");
`endif

    // random traffic with backpressure and withdrawn requests
    for (int c = 0; c < 1500; c++) begin
      tick();
      for (int i = 0; i < NREQ; i++) begin
        if (!pend[i]) begin
          if ($urandom_range(0, 3) == 0) begin
            ra = WIDTH'($urandom);
            rb = WIDTH'($urandom);
            new_req(i, ra, rb, 1'($urandom_range(0, 1)));
          end
        end else if ($urandom_range(0, 29) == 0) begin
          pend[i] = 1'b0;
        end
      end
      bus.rsp_ready = ($urandom_range(0, 9) < 7);
    end
    drain();
    check("rand_progress", 32'(n_rsp > 40), 32'd1);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
